// File: rtl/fir_pkg.sv
// fir_pkg: constants and types shared by the FIR filter, the decimator and
// the bench.
//   FIR_DATA_WIDTH : default sample width (two's complement FIR output)
//   FIR_DECIM      : default decimation ratio (power of 2, >= 2)
//   FIR_FIFO_DEPTH : default output FIFO depth (power of 2, >= 2)
//   DECIM_LOG2     : log2 of the default decimation ratio
//   FIFO_AW        : address width of the default output FIFO
//   sample_t       : signed sample of FIR_DATA_WIDTH bits
package fir_pkg;

  localparam int FIR_DATA_WIDTH = 10;
  localparam int FIR_DECIM      = 4;
  localparam int FIR_FIFO_DEPTH = 4;
  localparam int DECIM_LOG2     = $clog2(FIR_DECIM);
  localparam int FIFO_AW        = $clog2(FIR_FIFO_DEPTH);

  typedef logic signed [FIR_DATA_WIDTH-1:0] sample_t;

endpackage

// File: rtl/fir_sync_fifo.sv
// fir_sync_fifo: single-clock FIFO with a registered head word.
//   clk, rst     : clock, synchronous active-high reset
//   i_push       : write request (dropped internally when full and not popping)
//   i_push_data  : word to write
//   i_pop        : read request (ignored when empty)
//   o_head       : registered head word, stable until the next pop
//   o_full       : all DEPTH entries occupied
//   o_empty      : no entries
// Handshake: a pop takes effect on an edge where i_pop=1 and o_empty=0; a
// push takes effect on an edge where i_push=1 and (o_full=0 or a pop takes
// effect on that same edge). Neither output depends combinationally on
// i_push or i_pop.
module fir_sync_fifo
  import fir_pkg::*;
#(
  parameter int WIDTH = FIR_DATA_WIDTH,
  parameter int DEPTH = FIR_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra bit so full and empty can be told apart.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_head;

  logic        w_do_pop;
  logic        w_do_push;
  logic [AW:0] w_rd_next;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign w_rd_next = r_rd_ptr + {{AW{1'b0}}, w_do_pop};
  assign o_head    = r_head;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_head   <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      r_rd_ptr <= w_rd_next;
      // The pushed word lands at the next head slot only when the FIFO is
      // (or becomes) empty; in that case it must bypass the memory read.
      if (w_do_push && (r_wr_ptr[AW-1:0] == w_rd_next[AW-1:0])) begin
        r_head <= i_push_data;
      end else begin
        r_head <= r_mem[w_rd_next[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/fir_decimator.sv
// fir_decimator: decimate-by-DECIM stage behind the FIR filter, with an
// output FIFO and a sticky overflow flag.
//   clk, rst   : clock, synchronous active-high reset
//   in_data    : signed FIR output sample
//   in_valid   : in_data is valid (no back-pressure toward the FIR)
//   out_data   : signed decimated sample at the FIFO head
//   out_valid  : FIFO not empty
//   out_ready  : consumer takes the head this cycle
//   overflow   : sticky, a result was dropped on a full FIFO (rst clears)
// Handshake: a result is transferred on every edge with out_valid=1 and
// out_ready=1; out_data is held while out_valid=1 and out_ready=0.
// Build option: define FIR_DECIM_AVG_EN to output the floor average of each
// group of DECIM samples instead of the last sample of the group.
module fir_decimator
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = FIR_DATA_WIDTH,
  parameter int DECIM      = FIR_DECIM,
  parameter int FIFO_DEPTH = FIR_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         overflow
);

  localparam int                PH_W       = $clog2(DECIM);
  localparam logic [PH_W-1:0]   PHASE_LAST = PH_W'(DECIM - 1);

  logic [PH_W-1:0]       r_phase;
  logic                  r_overflow;
  logic                  w_last;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [DATA_WIDTH-1:0] w_result;
  logic [DATA_WIDTH-1:0] w_head;

  assign w_last = in_valid && (r_phase == PHASE_LAST);

  // Phase counter wraps naturally because DECIM is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= '0;
    end else if (in_valid) begin
      r_phase <= r_phase + 1'b1;
    end
  end

`ifdef FIR_DECIM_AVG_EN
  localparam int ACC_W = DATA_WIDTH + PH_W;

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_in_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_avg;

  assign w_in_ext = {{PH_W{in_data[DATA_WIDTH-1]}}, in_data};
  // Phase 0 starts a fresh group, so the stale accumulator is ignored.
  assign w_sum    = ((r_phase == '0) ? '0 : r_acc) + w_in_ext;
  // Arithmetic shift floors toward -inf; the mean of DECIM in-range
  // samples always fits back into DATA_WIDTH bits.
  assign w_avg    = w_sum >>> PH_W;
  assign w_result = w_avg[DATA_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (in_valid) begin
      r_acc <= w_sum;
    end
  end
`else
  assign w_result = in_data;
`endif

  assign w_pop = out_ready && !w_empty;

  // A result is lost only when the FIFO is full and nothing leaves it on
  // the same edge; a simultaneous pop frees the slot for the push.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_last && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  fir_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_last),
    .i_push_data (w_result),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign out_data  = w_head;
  assign out_valid = !w_empty;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_fir_decimator.sv
// tb_fir_decimator: directed bench for fir_decimator (DECIM=4, FIFO_DEPTH=4).
// Expected results are written out by hand for both the pick build and the
// FIR_DECIM_AVG_EN build.
module tb_fir_decimator;
  import fir_pkg::*;

  // clock / reset
  logic    clk = 1'b0;
  logic    rst;
  sample_t in_data;
  logic    in_valid;
  sample_t out_data;
  logic    out_valid;
  logic    out_ready;
  logic    overflow;

  always #5 clk = ~clk;

  fir_decimator #(
    .DATA_WIDTH (10),
    .DECIM      (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  int total = 0;
  int bad   = 0;
  logic [FIR_DATA_WIDTH-1:0] exp_q[$];

  // Hand-computed group results for samples 1..20 and 7..10.
`ifdef FIR_DECIM_AVG_EN
  localparam int E_1_4 = 2, E_5_8 = 6, E_9_12 = 10, E_13_16 = 14, E_17_20 = 18;
  localparam int E_7_10 = 8;
`else
  localparam int E_1_4 = 4, E_5_8 = 8, E_9_12 = 12, E_13_16 = 16, E_17_20 = 20;
  localparam int E_7_10 = 10;
`endif

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int d);
    in_valid = v;
    in_data  = sample_t'(d);
    tick();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 10'sh155;
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if (out_valid !== 1'b0 || out_data !== 10'sd0 || overflow !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold cyc%0d: valid=%b data=%0d ovf=%b required 0/0/0",
                 c, out_valid, out_data, overflow);
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, i);
      total++;
      if (i < 4) begin
        if (out_valid !== 1'b0) begin
          bad++;
          $display("FAIL reset_early_out s%0d: valid=%b required 0", i, out_valid);
        end
      end else if (out_valid !== 1'b1 || out_data !== sample_t'(E_1_4)) begin
        bad++;
        $display("FAIL reset_first_out: valid=%b data=%0d required 1/%0d",
                 out_valid, out_data, E_1_4);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_pick();
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, i);
      total++;
      if (i == 4 || i == 8) begin
        if (out_valid !== 1'b1 || out_data !== sample_t'((i == 4) ? E_1_4 : E_5_8)) begin
          bad++;
          $display("FAIL pick_out s%0d: valid=%b data=%0d required 1/%0d",
                   i, out_valid, out_data, (i == 4) ? E_1_4 : E_5_8);
        end
      end else if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL pick_gap s%0d: valid=%b required 0", i, out_valid);
      end
    end
    in_valid = 1'b0;
  endtask

`ifdef FIR_DECIM_AVG_EN
  task automatic test_avg();
    int g [3][4];
    int e [3];
    g = '{'{10, 20, 30, 40}, '{-1, -2, -2, -2}, '{511, 511, 511, 511}};
    e = '{25, -2, 511};
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 4; j++) begin
        drive(1'b1, g[k][j]);
      end
      total++;
      if (out_valid !== 1'b1 || out_data !== sample_t'(e[k])) begin
        bad++;
        $display("FAIL avg_group%0d: valid=%b data=%0d required 1/%0d",
                 k, out_valid, out_data, e[k]);
      end
    end
    in_valid = 1'b0;
  endtask
`endif

  task automatic test_back_pressure();
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, i);
      if (i == 16) begin
        total++;
        if (overflow !== 1'b0) begin
          bad++;
          $display("FAIL bp_ovf_early: ovf=%b required 0", overflow);
        end
      end
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL bp_ovf_set: ovf=%b required 1", overflow);
    end
    exp_q.push_back(10'(E_1_4));
    exp_q.push_back(10'(E_5_8));
    exp_q.push_back(10'(E_9_12));
    exp_q.push_back(10'(E_13_16));
    out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
        bad++;
        $display("FAIL bp_drain: valid=%b data=%0d required 1/%0d",
                 out_valid, out_data, $signed(exp_q[0]));
      end
      void'(exp_q.pop_front());
      tick();
    end
    total++;
    if (out_valid !== 1'b0 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL bp_after: valid=%b ovf=%b required 0/1", out_valid, overflow);
    end
  endtask

  // Full FIFO with a pop on the same edge as a push: nothing is dropped.
  task automatic test_full_push_pop();
    do_reset();
    for (int i = 1; i <= 19; i++) begin
      drive(1'b1, i);
    end
    out_ready = 1'b1;
    drive(1'b1, 20);
    in_valid = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL full_pop_ovf: ovf=%b required 0", overflow);
    end
    exp_q.push_back(10'(E_5_8));
    exp_q.push_back(10'(E_9_12));
    exp_q.push_back(10'(E_13_16));
    exp_q.push_back(10'(E_17_20));
    while (exp_q.size() > 0) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
        bad++;
        $display("FAIL full_pop_drain: valid=%b data=%0d required 1/%0d",
                 out_valid, out_data, $signed(exp_q[0]));
      end
      void'(exp_q.pop_front());
      tick();
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL full_pop_empty: valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_gapped();
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k % 2 == 0) drive(1'b1, k / 2 + 1);
      else            drive(1'b0, 99);
      total++;
      if (k == 6 || k == 14) begin
        if (out_valid !== 1'b1 || out_data !== sample_t'((k == 6) ? E_1_4 : E_5_8)) begin
          bad++;
          $display("FAIL gap_out k%0d: valid=%b data=%0d required 1/%0d",
                   k, out_valid, out_data, (k == 6) ? E_1_4 : E_5_8);
        end
      end else if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL gap_idle k%0d: valid=%b required 0", k, out_valid);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, i);
    end
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_queued: valid=%b required 1", out_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL mid_flush: valid=%b ovf=%b required 0/0", out_valid, overflow);
    end
    out_ready = 1'b1;
    for (int i = 7; i <= 10; i++) begin
      drive(1'b1, i);
      total++;
      if (i < 10) begin
        if (out_valid !== 1'b0) begin
          bad++;
          $display("FAIL mid_early s%0d: valid=%b required 0", i, out_valid);
        end
      end else if (out_valid !== 1'b1 || out_data !== sample_t'(E_7_10)) begin
        bad++;
        $display("FAIL mid_out: valid=%b data=%0d required 1/%0d",
                 out_valid, out_data, E_7_10);
      end
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_single: valid=%b required 0", out_valid);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_pick();
`ifdef FIR_DECIM_AVG_EN
    test_avg();
`endif
    test_back_pressure();
    test_full_push_pop();
    test_gapped();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_decimator.md
# fir_decimator

Decimate-by-N stage directly downstream of the 63-tap FIR filter. It consumes one signed filtered sample per clock and keeps every DECIM-th sample, or the block average when averaging is compiled in. Results are buffered in a small FIFO and presented on a valid/ready output port for the capture or next-stage logic. A sticky overflow flag reports any result dropped because of sustained back-pressure.

## Interface
- DATA_WIDTH, 10: sample width, two's complement, matches the FIR output.
- DECIM, 4: decimation ratio; must be ≥2 and a power of 2.
- FIFO_DEPTH, 4: output FIFO entries; must be ≥2 and a power of 2.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_data  input  DATA_WIDTH  signed FIR output sample.
- in_valid  input  1  in_data is valid this cycle. There is no in_ready; the FIR stage is never stalled.
- out_data  output  DATA_WIDTH  signed decimated sample (FIFO head).
- out_valid  output  1  FIFO is not empty.
- out_ready  input  1  consumer accepts the head this cycle.
- overflow  output  1  sticky flag: a decimated result was dropped.

## Operation
- Sample acceptance: a sample is accepted on any rising edge with in_valid=1. The phase counter (0..DECIM-1) advances on each accepted sample and wraps from DECIM-1 to 0.
- Result generation: the accepted sample at phase DECIM-1 produces one decimated result.
  - Pick mode: the result is in_data at that phase, i.e. the last sample of the group.
- FIFO write: the result is pushed into the FIFO in the same edge it is produced.
  - If the FIFO is full and no pop occurs that edge, the result is discarded and overflow is set.
  - If the FIFO is full and a pop occurs in the same edge, the push is accepted and no overflow is raised.
- Pop: occurs on any edge with out_valid=1 and out_ready=1. out_data holds the head and stays stable while out_valid=1 and out_ready=0.
- Empty FIFO: there is no bypass path. A result produced into an empty FIFO becomes visible on the next cycle.
- Overflow clearing: overflow is cleared only by rst.
- Reset values: out_valid=0, out_data=0, overflow=0, phase=0, accumulator=0, FIFO empty.
- Reset mid-operation: rst discards the partial group and all FIFO contents. No partial result is emitted.

## Timing
- Latency: out_valid rises one cycle after the edge that accepts the phase DECIM-1 sample, with out_data valid in that same cycle.
- Sustained rate: with continuous in_valid and out_ready=1, out_valid pulses for one cycle every DECIM cycles.
- Simultaneous push and pop on a non-full FIFO: both take effect; occupancy is unchanged.
- Idle input: in_valid=0 for any number of cycles freezes the phase counter and the accumulator. Output draining continues.
- Boundaries:
  - Pointers wrap modulo FIFO_DEPTH.
  - Full and empty are distinguished by an extra pointer bit.
  - No output combinationally depends on out_ready.

## Configuration
- FIR_DECIM_AVG_EN defined: the block outputs the average of each group.
  - An accumulator of DATA_WIDTH+log2(DECIM) bits sums the DECIM accepted samples of the group.
  - The accumulator restarts at phase 0.
  - The result is an arithmetic right shift by log2(DECIM) (floor toward −∞), then truncated to DATA_WIDTH. The truncation never loses information.
- FIR_DECIM_AVG_EN undefined: pick mode only. No accumulator is synthesised.

## Structure
- Shared package fir_pkg holds:
  - the DATA_WIDTH default;
  - typedef sample_t (signed logic [DATA_WIDTH-1:0]);
  - the localparams DECIM_LOG2 and FIFO_AW, derived via $clog2 and shared with the FIR filter and the bench.
- Sub-module fir_sync_fifo: a parameterised single-clock FIFO with push/pop/full/empty outputs and a registered head. It is instantiated once.
- The top level contains the phase counter, the optional accumulator, the push/overflow logic, and the FIFO instance.

## Test plan
All scenarios use DECIM=4 and FIFO_DEPTH=4.
- Reset: hold rst=1 for 2 cycles with in_valid=1 and in_data=0x155 → out_valid=0, out_data=0, overflow=0 throughout. No output appears until 4 samples have been accepted after rst falls.
- Pick mode: inputs 1..8 on consecutive cycles, out_ready=1 → out_data=4 with a one-cycle out_valid the cycle after input 4, then out_data=8 the cycle after input 8.
- Averaging (FIR_DECIM_AVG_EN): inputs 10,20,30,40 → 25. Inputs −1,−2,−2,−2 (sum −7) → −2. Inputs 511,511,511,511 → 511.
- Back-pressure: out_ready=0 while inputs 1..20 are applied → FIFO holds 4,8,12,16; result 20 is dropped and overflow=1. Then out_ready=1 → outputs 4,8,12,16 in order, and overflow stays 1.
- Gapped input: in_valid alternates 1/0 with values 1..8 on the valid cycles → outputs 4 and 8 only. Each output appears one cycle after its 4th valid sample.
- Reset mid-group: accept 5 and 6, queue one unread result, then pulse rst for one cycle → FIFO empty and phase 0. The next inputs 7,8,9,10 produce a single output of 10 (pick mode) or 8 (averaging mode).
